// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t     : FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   DEF_WIDTH   : default operand width
//   cnt_width() : width of the step counter, which must hold the value WIDTH
package seq_divider_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step (combinational).
//   rem      in  WIDTH    current partial remainder (always < divisor)
//   dvd_msb  in  1        dividend bit being shifted into the remainder
//   dvs      in  WIDTH    divisor
//   rem_next out WIDTH    partial remainder after this step
//   qbit     out 1        quotient bit produced by this step
// The trial subtraction is done in WIDTH+1 bits; its MSB is the sign.
// Because the incoming remainder is below the divisor, the restored or
// subtracted result is again below the divisor and fits in WIDTH bits.
module seq_divider_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = shifted - {1'b0, dvs};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk       in  1         system clock (rising edge)
//   rst       in  1         synchronous active-high reset
//   num1      in  WIDTH     dividend, sampled on an accepted valid
//   num2      in  WIDTH     divisor, sampled on an accepted valid
//   valid     in  1         request strobe, accepted in IDLE or DONE
//   busy      out 1         operation in progress
//   ready     out 1         result valid until the next accepted valid
//   div_zero  out 1         divisor was zero (quotient all-ones, remainder num1)
//   result    out 2*WIDTH   {remainder, quotient}
//   dbg_state out state_t   current FSM state, for observation only
// Handshake: a request is taken on any rising edge where valid=1 and the
// FSM is in IDLE or DONE; valid during BUSY is ignored. ready rises when a
// result is available and stays high, with result stable, until the next
// request is taken. All outputs are registered.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic               valid,
  output logic               busy,
  output logic               ready,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result,
  output state_t             dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic             accept;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (valid) begin
          accept  = 1'b1;
          state_d = (num2 == '0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Count reaching zero means all WIDTH bits are done; this extra
        // edge publishes the result.
        if (count_q == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      if (num2 == '0) begin
        result   <= {num1, {WIDTH{1'b1}}};
        ready    <= 1'b1;
        div_zero <= 1'b1;
        busy     <= 1'b0;
      end else begin
        dvd_q    <= num1;
        dvs_q    <= num2;
        rem_q    <= '0;
        count_q  <= CW'(WIDTH);
        ready    <= 1'b0;
        div_zero <= 1'b0;
        busy     <= 1'b1;
      end
    end else if (state_q == ST_BUSY) begin
      if (count_q == '0) begin
        result <= {rem_q, dvd_q};
        ready  <= 1'b1;
        busy   <= 1'b0;
      end else begin
        // Quotient bits fill the dividend register from the LSB as its
        // MSBs are consumed, so it ends up holding the quotient.
        rem_q   <= rem_next;
        dvd_q   <= {dvd_q[WIDTH-2:0], qbit};
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic [W-1:0]   num1, num2;
  logic           busy, ready, div_zero;
  logic [2*W-1:0] result;
  state_t         dbg_state;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .num1      (num1),
    .num2      (num2),
    .valid     (valid),
    .busy      (busy),
    .ready     (ready),
    .div_zero  (div_zero),
    .result    (result),
    .dbg_state (dbg_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: an accepted request with a nonzero divisor
  // yields {a%b, a/b} after W+1 edges; a zero divisor answers at once.
  logic           m_init = 1'b0;
  logic           m_busy, m_ready, m_dz, m_known;
  logic [2*W-1:0] m_res, m_pend;
  int             m_left;
  logic [2*W-1:0] exp_q[$];   // results expected from the model, in order

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_dz    <= 1'b0;
      m_res   <= '0;
      m_known <= 1'b1;
      m_left  <= 0;
    end else if (m_init && !m_busy && valid) begin
      if (num2 == '0) begin
        m_ready <= 1'b1;
        m_dz    <= 1'b1;
        m_res   <= {num1, 16'hFFFF};
        m_known <= 1'b1;
      end else begin
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
        m_dz    <= 1'b0;
        m_known <= 1'b0;
        m_pend  <= {num1 % num2, num1 / num2};
        m_left  <= W + 1;
      end
    end else if (m_init && m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= m_pend;
        m_known <= 1'b1;
      end
      m_left <= m_left - 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("ready", {31'd0, ready}, {31'd0, m_ready});
      check("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
      if (m_known) check("result", result, m_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    num1  = a;
    num2  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until ready is seen.
  task automatic wait_ready(output int n, output int busy_seen);
    n = 0;
    busy_seen = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      if (busy) busy_seen++;
    end
    if (!ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 edges");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      default: return W'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, bs;
    rst = 1'b1; valid = 1'b0; num1 = '0; num2 = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // 100 / 7: latency and literal result
    send(16'd100, 16'd7);
    wait_ready(n, bs);
    check("lat_100_7", n, 32'd17);
    check("busy_cycles_100_7", bs, 32'd16);
    check("res_100_7", result, {16'd2, 16'd14});
    check("dz_100_7", {31'd0, div_zero}, 32'd0);

    send(16'hFFFF, 16'd1);
    wait_ready(n, bs);
    check("res_ffff_1", result, {16'd0, 16'hFFFF});
    send(16'hFFFF, 16'hFFFF);
    wait_ready(n, bs);
    check("res_ffff_ffff", result, {16'd0, 16'd1});

    send(16'd3, 16'd10);
    wait_ready(n, bs);
    check("res_3_10", result, {16'd3, 16'd0});
    send(16'd5, 16'd0);
    check("dz_ready_5_0", {31'd0, ready}, 32'd1);
    check("dz_flag_5_0", {31'd0, div_zero}, 32'd1);
    check("dz_busy_5_0", {31'd0, busy}, 32'd0);
    check("res_5_0", result, {16'd5, 16'hFFFF});

    // Request while busy is ignored; request in DONE starts a new op
    send(16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    num1 = 16'd9; num2 = 16'd9; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_ready(n, bs);
    check("res_1000_3", result, {16'd1, 16'd333});
    @(negedge clk);
    num1 = 16'd50; num2 = 16'd6; valid = 1'b1;
    @(posedge clk);
    #1;
    check("done_accept_ready", {31'd0, ready}, 32'd0);
    check("done_accept_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    valid = 1'b0;
    wait_ready(n, bs);
    check("res_50_6", result, {16'd2, 16'd8});

    // Reset mid-operation
    send(16'd60000, 16'd7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(16'd60000, 16'd7);
    wait_ready(n, bs);
    check("res_60000_7", result, {16'd3, 16'd8571});

    send(16'd0, 16'd0);
    check("res_0_0", result, {16'd0, 16'hFFFF});
    send(16'd0, 16'd5);
    wait_ready(n, bs);
    check("res_0_5", result, {16'd0, 16'd0});

    // Back-to-back random operation with valid held high
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 700; i++) begin
      num1 = pick();
      num2 = pick();
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
